// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bundle: two writers (pipeline writeback A, mul/div B),
// long-op issue tracking, read-hazard queries and the RegisterFile write port.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              AValid;
    logic              AReady;
    logic [ADDR_W-1:0] AReg;
    logic [DATA_W-1:0] AData;

    logic              BValid;
    logic              BReady;
    logic [ADDR_W-1:0] BReg;
    logic [DATA_W-1:0] BData;

    logic              IssueValid;
    logic [ADDR_W-1:0] IssueReg;

    logic [ADDR_W-1:0] QueryReg1;
    logic [ADDR_W-1:0] QueryReg2;
    logic              Busy1;
    logic              Busy2;

    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;

    // Requesters / hazard logic / register file side
    modport master (
        output AValid, AReg, AData,
        output BValid, BReg, BData,
        output IssueValid, IssueReg,
        output QueryReg1, QueryReg2,
        input  AReady, BReady, Busy1, Busy2,
        input  RegWrite, WriteReg, WriteData
    );

    // Arbiter side
    modport slave (
        input  AValid, AReg, AData,
        input  BValid, BReg, BData,
        input  IssueValid, IssueReg,
        input  QueryReg1, QueryReg2,
        output AReady, BReady, Busy1, Busy2,
        output RegWrite, WriteReg, WriteData
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single RegisterFile write port between the writeback stage (A, fixed
// priority) and the mul/div unit (B, forced through after MAX_WAIT lost cycles),
// and tracks which registers still await a long-latency result.
// DATA_W/ADDR_W must match the parameters of the connected interface instance.
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [3:0]      waitCnt;
    logic            srcB;
    logic            starve;
    logic            grantA;
    logic            grantB;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pendingNext;

    // Grant decision: A wins unless B has lost MAX_WAIT cycles in a row
    always_comb begin
        starve = (waitCnt == 4'(MAX_WAIT));
        grantB = bus.BValid && (!bus.AValid || starve);
        grantA = bus.AValid && !grantB;
    end

    assign bus.AReady = grantA;
    assign bus.BReady = grantB;

    // Register 0 is never pending, so bit 0 of the scoreboard stays clear
    assign bus.Busy1 = pending[bus.QueryReg1];
    assign bus.Busy2 = pending[bus.QueryReg2];

    // Count consecutive cycles B waited; saturates so starve stays asserted until B wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= '0;
        end else if (!bus.BValid || grantB) begin
            waitCnt <= '0;
        end else if (!starve) begin
            waitCnt <= waitCnt + 4'd1;
        end
    end

    // Write-port register stage: the granted write is presented to RegisterFile next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.RegWrite  <= 1'b0;
            bus.WriteReg  <= '0;
            bus.WriteData <= '0;
            srcB          <= 1'b0;
        end else if (grantB) begin
            bus.RegWrite  <= (bus.BReg != '0);
            bus.WriteReg  <= bus.BReg;
            bus.WriteData <= bus.BData;
            srcB          <= 1'b1;
        end else if (grantA) begin
            bus.RegWrite  <= (bus.AReg != '0);
            bus.WriteReg  <= bus.AReg;
            bus.WriteData <= bus.AData;
            srcB          <= 1'b0;
        end else begin
            bus.RegWrite  <= 1'b0;
            srcB          <= 1'b0;
        end
    end

    // Next scoreboard: clear on the edge RegisterFile commits a B write, then apply a
    // new issue so that a same-index set wins (a newer long op is in flight)
    always_comb begin
        pendingNext = pending;
        if (bus.RegWrite && srcB) begin
            pendingNext[bus.WriteReg] = 1'b0;
        end
        if (bus.IssueValid) begin
            pendingNext[bus.IssueReg] = 1'b1;
        end
        pendingNext[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected RegisterFile writes are queued
// as stimulus is issued and a negedge monitor pops/compares every RegWrite pulse.
module tb_regfile_write_arbiter;
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    wr_t  expQ[$];
    logic [31:0] rf [32];

    regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RegisterFile fed by the DUT write port
    always @(posedge clk) begin
        if (bus.RegWrite) rf[bus.WriteReg] <= bus.WriteData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        wr_t w;
        w.r = r;
        w.d = d;
        expQ.push_back(w);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every RegWrite pulse must match the oldest expected write
    always @(negedge clk) begin
        if (bus.RegWrite) begin
            if (expQ.size() == 0) begin
                check("unexpectedWrite", {27'd0, bus.WriteReg}, 32'hFFFFFFFF);
            end else begin
                wr_t w;
                w = expQ.pop_front();
                check("WriteReg", {27'd0, bus.WriteReg}, {27'd0, w.r});
                check("WriteData", bus.WriteData, w.d);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n = 1'b0;
        bus.AValid = 0; bus.AReg = 0; bus.AData = 0;
        bus.BValid = 0; bus.BReg = 0; bus.BData = 0;
        bus.IssueValid = 0; bus.IssueReg = 0;
        bus.QueryReg1 = 0; bus.QueryReg2 = 0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.AValid = 1'($urandom); bus.AReg = 5'($urandom); bus.AData = $urandom;
            bus.BValid = 1'($urandom); bus.BReg = 5'($urandom); bus.BData = $urandom;
            bus.IssueValid = 1'($urandom); bus.IssueReg = 5'($urandom);
            bus.QueryReg1 = 5'($urandom); bus.QueryReg2 = 5'($urandom);
            #2;
            check("rstRegWrite", {31'd0, bus.RegWrite}, 32'd0);
            check("rstWriteReg", {27'd0, bus.WriteReg}, 32'd0);
            check("rstWriteData", bus.WriteData, 32'd0);
            check("rstBusy1", {31'd0, bus.Busy1}, 32'd0);
            check("rstBusy2", {31'd0, bus.Busy2}, 32'd0);
        end
        cyc();
        bus.AValid = 0; bus.BValid = 0; bus.IssueValid = 0;
        bus.QueryReg1 = 0; bus.QueryReg2 = 0;
        rst_n = 1'b1;

        // First A write after reset
        cyc();
        bus.AValid = 1; bus.AReg = 5; bus.AData = 32'hCAFEBABE;
        #1;
        check("firstAReady", {31'd0, bus.AReady}, 32'd1);
        check("firstBReady", {31'd0, bus.BReady}, 32'd0);
        push(5, 32'hCAFEBABE);

        // Write to register 0: handshake completes, RegWrite stays low
        cyc();
        bus.AReg = 0; bus.AData = 32'hFFFFFFFF;
        #1;
        check("r0AReady", {31'd0, bus.AReady}, 32'd1);
        cyc();
        bus.AValid = 0;
        bus.IssueValid = 1; bus.IssueReg = 0; bus.QueryReg1 = 0;
        #1;
        check("r0RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        cyc();
        bus.IssueValid = 0;
        #1;
        check("r0Busy", {31'd0, bus.Busy1}, 32'd0);

        // Starvation: A and B both valid, B forced through on the 5th cycle
        cyc();
        bus.AValid = 1; bus.BValid = 1; bus.BReg = 20; bus.BData = 32'hB0B0B0B0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) cyc();
            bus.AReg = 5'(10 + c);
            bus.AData = 32'hA0000000 + 32'(c);
            if (c == 5) bus.BValid = 0;
            #1;
            check($sformatf("starveAReady%0d", c), {31'd0, bus.AReady}, (c == 4) ? 32'd0 : 32'd1);
            check($sformatf("starveBReady%0d", c), {31'd0, bus.BReady}, (c == 4) ? 32'd1 : 32'd0);
            if (c == 4) push(20, 32'hB0B0B0B0);
            else        push(5'(10 + c), 32'hA0000000 + 32'(c));
        end
        cyc();
        bus.AValid = 0;

        // Scoreboard: issue reg 9, then B writes it
        bus.IssueValid = 1; bus.IssueReg = 9; bus.QueryReg1 = 9; bus.QueryReg2 = 9;
        cyc();
        bus.IssueValid = 0;
        #1;
        check("issueBusy1", {31'd0, bus.Busy1}, 32'd1);
        check("issueBusy2", {31'd0, bus.Busy2}, 32'd1);
        cyc();
        bus.BValid = 1; bus.BReg = 9; bus.BData = 32'h12345678;
        #1;
        check("sbBReady", {31'd0, bus.BReady}, 32'd1);
        check("sbBusyN", {31'd0, bus.Busy1}, 32'd1);
        push(9, 32'h12345678);
        cyc();
        bus.BValid = 0;
        #1;
        check("sbBusyN1", {31'd0, bus.Busy1}, 32'd1);
        cyc();
        #1;
        check("sbBusyN2", {31'd0, bus.Busy1}, 32'd0);
        check("sbRfData", rf[9], 32'h12345678);

        // Set wins over clear on the same edge for reg 7
        bus.IssueValid = 1; bus.IssueReg = 7; bus.QueryReg1 = 7;
        cyc();
        bus.IssueValid = 0;
        #1;
        check("r7Busy", {31'd0, bus.Busy1}, 32'd1);
        cyc();
        bus.BValid = 1; bus.BReg = 7; bus.BData = 32'h00000077;
        push(7, 32'h00000077);
        cyc();
        bus.BValid = 0;
        bus.IssueValid = 1; bus.IssueReg = 7;
        cyc();
        bus.IssueValid = 0;
        #1;
        check("setWinsBusy", {31'd0, bus.Busy1}, 32'd1);
        // A write to reg 7 must leave pending untouched
        bus.AValid = 1; bus.AReg = 7; bus.AData = 32'h0000AAAA;
        push(7, 32'h0000AAAA);
        cyc();
        bus.AValid = 0;
        cyc();
        #1;
        check("aWriteKeepsBusy", {31'd0, bus.Busy1}, 32'd1);

        // Async reset mid-stream with a write in flight and reg 3 pending
        bus.IssueValid = 1; bus.IssueReg = 3; bus.QueryReg2 = 3;
        bus.AValid = 1; bus.AReg = 4; bus.AData = 32'h00000044;
        push(4, 32'h00000044);
        cyc();
        bus.IssueValid = 0; bus.AValid = 0;
        #1;
        check("preRstRegWrite", {31'd0, bus.RegWrite}, 32'd1);
        check("preRstBusy2", {31'd0, bus.Busy2}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("asyncRegWrite", {31'd0, bus.RegWrite}, 32'd0);
        check("asyncBusy2", {31'd0, bus.Busy2}, 32'd0);
        check("asyncBusy1", {31'd0, bus.Busy1}, 32'd0);
        check("asyncWriteData", bus.WriteData, 32'd0);
        expQ.delete();
        cyc();
        cyc();
        rst_n = 1'b1;

        // Normal operation resumes after reset
        cyc();
        bus.AValid = 1; bus.AReg = 31; bus.AData = 32'h5A5A5A5A;
        #1;
        check("postRstAReady", {31'd0, bus.AReady}, 32'd1);
        push(31, 32'h5A5A5A5A);
        cyc();
        bus.AValid = 0;
        cyc();
        cyc();
        check("queueDrained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
